interval_timer_ctrl: RTL
========================

# interval_timer_ctrl

Programmable interval timer controller. It sequences a runtime-modulus prescaler and a down-counter to produce one-shot or periodic timeout ticks. It sits between a control source (register block or FSM issuing start/stop with load values) and tick consumers such as UART baud logic, debouncers and display multiplexers. It replaces fixed-parameter mod-M counters where the period must change at run time.

## Interface
Parameters:
- N, 16, width of interval load value and count.
- P, 8, width of prescaler divide value.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- start  in  1  level-sampled each clock; begins or restarts timing.
- stop  in  1  level-sampled each clock; aborts timing.
- periodic  in  1  mode sampled with start: 1 = auto-reload, 0 = one-shot.
- load  in  N  interval in prescaled ticks, sampled with start.
- presc  in  P  prescale divide minus one, sampled with start (0 = every clock).
- busy  out  1  high while in RUN.
- done_tick  out  1  one-clock pulse at interval expiry.
- count  out  N  remaining prescaled ticks in the current interval.

## Operation
- States: IDLE, RUN. Encoding is 1 bit.
- Internal registers: state, mode_reg, load_reg[N], presc_reg[P], p_reg[P] (prescaler), count_reg[N].
- Prescaler: in RUN, p_reg counts 0..presc_reg and wraps to 0. ptick = RUN & (p_reg == presc_reg).
- IDLE:
  - start=1, stop=0, load!=0: capture load/presc/periodic; count_reg<=load; p_reg<=0; go to RUN.
  - start with load==0: ignored; stay IDLE; no pulse.
- RUN, in priority order:
  - stop=1: go to IDLE; count_reg<=0; p_reg<=0; no done_tick that cycle, even if ptick coincides.
  - start=1 with load!=0: restart. Recapture all inputs, count_reg<=load, p_reg<=0. Suppresses any coincident done_tick.
  - start=1 with load==0: treated as stop.
  - ptick & count_reg>1: count_reg decrements by 1.
  - ptick & count_reg==1: done_tick=1.
    - Periodic: count_reg<=load_reg and stay in RUN.
    - One-shot: count_reg<=0 and go to IDLE.
- Outputs:
  - done_tick = RUN & ptick & (count_reg==1) & ~stop & ~start. This is combinational from registers and inputs.
  - busy = (state==RUN).
  - count = count_reg.
- Arithmetic: unsigned. The decrement never wraps below 0. p_reg compare is a P-bit equality.

## Timing
- Reset (async assert, sync release): state=IDLE, all registers 0. busy=0, done_tick=0, count=0.
- Start accepted on edge E: busy=1 and count=load from the cycle after E.
- First done_tick occurs in the cycle ending at edge E + load*(presc+1).
- Periodic mode: subsequent done_ticks every load*(presc+1) cycles, with no gap cycle.
- One-shot mode: busy falls on the edge that ends the done_tick cycle.
- presc=0, load=1: done_tick in the first RUN cycle. Periodic mode then gives done_tick every cycle.
- Maximum period: 2^N-1 times 2^P clocks. No counter overflows.
- Reset asserted mid-RUN: immediate return to reset values, with no done_tick.

## Structure
- Package interval_timer_pkg:
  - state localparams ST_IDLE=0, ST_RUN=1;
  - mode constants MODE_ONESHOT=0, MODE_PERIODIC=1.
- Sub-module prog_mod_counter:
  - parameter W;
  - inputs clk, reset_n, clr, en, m[W];
  - outputs tick and q;
  - counts 0..m when en, clr is synchronous.
  - It is instantiated with W=P as the prescaler. clr is driven on start/stop/expiry-to-IDLE, and en=busy.
- The down-counter and FSM live in interval_timer_ctrl.

## Test plan
- Reset: hold reset_n=0 for 3 clocks mid-RUN (load=5) -> busy=0, count=0, done_tick never asserted. After release the block stays IDLE.
- One-shot: start with load=4, presc=2, periodic=0 -> done_tick exactly 12 clocks after the start edge. busy low the next cycle, count=0.
- Periodic: load=3, presc=0, periodic=1, run 10 clocks -> done_tick on cycles 3, 6 and 9 after start. count sequence 3,2,1,3,2,1...
- Stop coincident with expiry: load=2, presc=1, assert stop in the expiry cycle -> no done_tick, IDLE next cycle.
- Restart: at count=1 with ptick pending, start with load=6 -> no done_tick, count=6 next cycle, new period 6*(presc+1).
- Zero load: start with load=0 in IDLE -> stays IDLE. In RUN -> behaves as stop, busy drops next cycle.

Source files
------------

// File: rtl/interval_timer_pkg.sv
// Shared state and mode definitions for the programmable interval timer.
package interval_timer_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   localparam logic MODE_ONESHOT  = 1'b0;
   localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/prog_mod_counter.sv
// Runtime-modulus counter: counts 0..m while enabled and wraps, with synchronous clear.
module prog_mod_counter #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         clr,
   input  logic         en,
   input  logic [W-1:0] m,
   output logic         tick,
   output logic [W-1:0] q
);

   logic [W-1:0] q_reg, q_next;

   assign tick = en & (q_reg == m);
   assign q    = q_reg;

   always_comb begin
      q_next = q_reg;
      if (clr) begin
         q_next = '0;
      end else if (en) begin
         q_next = tick ? '0 : q_reg + W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         q_reg <= '0;
      end else begin
         q_reg <= q_next;
      end
   end

endmodule

// File: rtl/interval_timer_ctrl.sv
// Interval timer: prescaler plus down-counter giving one-shot or periodic done ticks.
module interval_timer_ctrl
   import interval_timer_pkg::*;
#(
   parameter int unsigned N = 16,
   parameter int unsigned P = 8
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         start,
   input  logic         stop,
   input  logic         periodic,
   input  logic [N-1:0] load,
   input  logic [P-1:0] presc,
   output logic         busy,
   output logic         done_tick,
   output logic [N-1:0] count
);

   state_t       state, state_next;
   logic         mode_reg, mode_next;
   logic [N-1:0] load_reg, load_next;
   logic [N-1:0] count_reg, count_next;
   logic [P-1:0] presc_reg, presc_next;
   logic [P-1:0] p_reg;
   logic [P-1:0] unused_p_reg;
   logic         ptick, p_clr, load_ok;

   assign load_ok      = (load != '0);
   assign busy         = (state == ST_RUN);
   assign count        = count_reg;
   assign unused_p_reg = p_reg;

   // Prescaler only advances in RUN, so its tick already carries the RUN qualifier.
   prog_mod_counter #(
      .W(P)
   ) u_presc (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (p_clr),
      .en      (busy),
      .m       (presc_reg),
      .tick    (ptick),
      .q       (p_reg)
   );

   always_comb begin
      state_next = state;
      mode_next  = mode_reg;
      load_next  = load_reg;
      presc_next = presc_reg;
      count_next = count_reg;
      p_clr      = 1'b0;
      done_tick  = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (start && !stop && load_ok) begin
               state_next = ST_RUN;
               mode_next  = periodic;
               load_next  = load;
               presc_next = presc;
               count_next = load;
               p_clr      = 1'b1;
            end
         end
         ST_RUN: begin
            // Stop and restart both outrank expiry, which suppresses a coincident tick.
            if (stop || (start && !load_ok)) begin
               state_next = ST_IDLE;
               count_next = '0;
               p_clr      = 1'b1;
            end else if (start) begin
               mode_next  = periodic;
               load_next  = load;
               presc_next = presc;
               count_next = load;
               p_clr      = 1'b1;
            end else if (ptick) begin
               if (count_reg > N'(1)) begin
                  count_next = count_reg - N'(1);
               end else if (count_reg == N'(1)) begin
                  done_tick = 1'b1;
                  if (mode_reg == MODE_PERIODIC) begin
                     count_next = load_reg;
                  end else begin
                     state_next = ST_IDLE;
                     count_next = '0;
                     p_clr      = 1'b1;
                  end
               end
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= ST_IDLE;
         mode_reg  <= MODE_ONESHOT;
         load_reg  <= '0;
         presc_reg <= '0;
         count_reg <= '0;
      end else begin
         state     <= state_next;
         mode_reg  <= mode_next;
         load_reg  <= load_next;
         presc_reg <= presc_next;
         count_reg <= count_next;
      end
   end

endmodule
